ysyx_ifu: RTL and testbench
===========================

YSYX_IFU -- requirements
Module: ysyx_ifu

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, output, 1, instruction-memory read request valid.
REQ-005 The block SHALL have port req_ready, input, 1, memory accepts the request.
REQ-006 The block SHALL have port req_addr, output, 32, fetch address (word aligned).
REQ-007 The block SHALL have port resp_valid, input, 1, read data valid; arrives no earlier than the cycle after the request handshake.
REQ-008 The block SHALL have port resp_data, input, 32, fetched instruction word.
REQ-009 The block SHALL have port out_valid, output, 1, instruction offered to the decode stage.
REQ-010 The block SHALL have port out_ready, input, 1, decode stage accepts the instruction.
REQ-011 The block SHALL have port out_inst, output, 32, instruction word to decode.
REQ-012 The block SHALL have port out_pc, output, 32, PC of out_inst.
REQ-013 The block SHALL have port redirect_valid, input, 1, branch/jump redirect from downstream.
REQ-014 The block SHALL have port redirect_pc, input, 32, redirect target.

Function
REQ-015 The block SHALL implement the states S_REQ, S_WAIT and S_OUT, and SHALL hold at most one outstanding memory request.
REQ-016 In S_REQ the block SHALL drive req_valid=1 and req_addr=pc, keep req_addr stable until the handshake, and move to S_WAIT on req_valid&&req_ready.
REQ-017 In S_WAIT, on resp_valid, the block SHALL latch resp_data into out_inst and move to S_OUT.
REQ-018 In S_OUT the block SHALL present out_valid = !redirect_valid, with out_pc=pc; on out_valid&&out_ready it SHALL set pc<=pc+4 (mod 2^32 wrap) and move to S_REQ.
REQ-019 out_inst and out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 redirect_valid SHALL have priority over every other event in every state, and SHALL load pc<=redirect_pc with bits [1:0] forced to 0.
REQ-021 A redirect in S_REQ without a handshake SHALL keep the block in S_REQ, with the new address driven on the next cycle.
REQ-022 A redirect in S_REQ with a handshake in the same cycle SHALL move the block to S_WAIT with drop=1.
REQ-023 A redirect in S_WAIT with no response in the same cycle SHALL set drop=1 and keep the block in S_WAIT.
REQ-024 A redirect in S_WAIT with resp_valid in the same cycle SHALL discard that response and move the block to S_REQ.
REQ-025 In S_WAIT with drop=1, resp_valid SHALL discard the data, clear drop, and move the block to S_REQ; out_valid SHALL never assert for a dropped response.
REQ-026 A redirect in S_OUT SHALL discard the held instruction, with no transfer that cycle even if out_ready=1, and move the block to S_REQ.
REQ-027 Best-case throughput SHALL be one instruction per 3 cycles: REQ handshake, then response, then output handshake.

Reset
REQ-028 While rst_n=0 the block SHALL hold state=S_REQ, pc=RESET_PC, drop=0, out_inst=0, req_valid=0 and out_valid=0.
REQ-029 Assertion of rst_n mid-request SHALL abandon the request; after release, any stale resp_valid in S_REQ SHALL be ignored.
REQ-030 req_valid SHALL first assert in the first cycle after rst_n deasserts, with req_addr=RESET_PC.

Verification
REQ-031 The bench SHALL cover reset release, with ready memory and 1-cycle response 32'h0000_0413 -> req_addr=32'h8000_0000, then out_valid with out_inst=32'h0000_0413 and out_pc=32'h8000_0000, then next req_addr=32'h8000_0004.
REQ-032 The bench SHALL cover out_ready held 0 for 5 cycles -> out_valid, out_inst and out_pc stable, no new req_valid, pc unchanged.
REQ-033 The bench SHALL cover a redirect to 32'h8000_0102 while in S_WAIT -> the pending response is dropped, no out_valid for it, and the next req_addr=32'h8000_0100.
REQ-034 The bench SHALL cover redirect_valid and out_ready both high in S_OUT -> out_valid=0 that cycle, and the next fetch uses the redirect target.
REQ-035 The bench SHALL cover pc=32'hFFFF_FFFC consumed -> next req_addr=32'h0000_0000.
REQ-036 The bench SHALL cover rst_n pulsed low during S_WAIT -> outputs return to reset values immediately, and refetch starts from 32'h8000_0000.

Source files
------------

// File: rtl/ysyx_ifu.sv
// rtl/ysyx_ifu.sv - instruction fetch unit with a single outstanding memory request
//
// Purpose: fetches one instruction word at a time from instruction memory and
// hands it to the decode stage, honouring branch/jump redirects from downstream.
//
// Parameters:
//   RESET_PC        first fetch address after reset
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   req_valid/ready instruction-memory request handshake
//   req_addr        word-aligned fetch address
//   resp_valid      read data valid (earliest the cycle after the request handshake)
//   resp_data       fetched instruction word
//   out_valid/ready decode-stage handshake
//   out_inst        instruction word to decode
//   out_pc          PC of out_inst
//   redirect_valid  redirect request from downstream (highest priority)
//   redirect_pc     redirect target (low two bits ignored)

module ysyx_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  // Set when the in-flight response belongs to a fetch that a redirect has
  // made obsolete; that response must be swallowed, not forwarded.
  logic        drop;

  logic [31:0] redirect_target;
  logic        req_fire;
  logic        out_fire;

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // rst_n is folded in so the request stays low while reset is held, even
  // though the state register already sits in S_REQ.
  assign req_valid = rst_n && (state == S_REQ);
  assign req_addr  = pc;
  assign req_fire  = req_valid && req_ready;

  // A redirect kills the offered instruction in the same cycle.
  assign out_valid = (state == S_OUT) && !redirect_valid;
  assign out_pc    = pc;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      out_inst <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            // Request with the old address already accepted: its reply is stale.
            if (req_fire) begin
              state <= S_WAIT;
              drop  <= 1'b1;
            end
          end else if (req_fire) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            if (resp_valid) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              drop  <= 1'b1;
            end
          end else if (resp_valid) begin
            if (drop) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              out_inst <= resp_data;
              state    <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (redirect_valid) begin
            pc    <= redirect_target;
            state <= S_REQ;
          end else if (out_fire) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end

        default: begin
          state <= S_REQ;
          drop  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_ifu.sv
// tb/tb_ysyx_ifu.sv - directed self-checking bench for ysyx_ifu

module tb_ysyx_ifu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_chk;
  int n_fail;

  ysyx_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic step();
    @(negedge clk);
  endtask

  // From S_REQ at addr: handshake, 1-cycle response, end in S_OUT offering inst.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] inst);
    step(); req_ready = 1'b1; #1;
    check({tag, ".req_valid"}, {31'b0, req_valid}, 32'd1);
    check({tag, ".req_addr"}, req_addr, addr);
    step(); req_ready = 1'b0; resp_valid = 1'b1; resp_data = inst; #1;
    check({tag, ".wait_req_valid"}, {31'b0, req_valid}, 32'd0);
    check({tag, ".wait_out_valid"}, {31'b0, out_valid}, 32'd0);
    step(); resp_valid = 1'b0; resp_data = 32'h0; #1;
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".out_inst"}, out_inst, inst);
    check({tag, ".out_pc"}, out_pc, addr);
  endtask

  // In S_OUT: accept the instruction, then check the next request address.
  task automatic consume(input string tag, input logic [31:0] next_addr);
    step(); out_ready = 1'b1; #1;
    check({tag, ".fire_valid"}, {31'b0, out_valid}, 32'd1);
    step(); out_ready = 1'b0; #1;
    check({tag, ".next_req_valid"}, {31'b0, req_valid}, 32'd1);
    check({tag, ".next_req_addr"}, req_addr, next_addr);
    check({tag, ".next_out_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset state
    repeat (2) step();
    #1;
    check("rst.req_valid", {31'b0, req_valid}, 32'd0);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.out_inst", out_inst, 32'h0);

    // Release reset; request appears immediately with RESET_PC
    step(); rst_n = 1'b1; #1;
    check("rel.req_valid", {31'b0, req_valid}, 32'd1);
    check("rel.req_addr", req_addr, 32'h8000_0000);

    // Basic fetch, 3-cycle turnaround
    fetch("f0", 32'h8000_0000, 32'h0000_0413);
    consume("f0", 32'h8000_0004);

    // Decode stalls for 5 cycles: everything holds, no new request
    fetch("stall", 32'h8000_0004, 32'h0010_0093);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      check("stall.out_valid", {31'b0, out_valid}, 32'd1);
      check("stall.out_inst", out_inst, 32'h0010_0093);
      check("stall.out_pc", out_pc, 32'h8000_0004);
      check("stall.req_valid", {31'b0, req_valid}, 32'd0);
    end
    consume("stall", 32'h8000_0008);

    // Redirect while waiting: response dropped, refetch from aligned target
    step(); req_ready = 1'b1; #1;
    check("rw.req_addr", req_addr, 32'h8000_0008);
    step(); req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; #1;
    check("rw.redir_out_valid", {31'b0, out_valid}, 32'd0);
    step(); redirect_valid = 1'b0; resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF; #1;
    check("rw.resp_out_valid", {31'b0, out_valid}, 32'd0);
    check("rw.resp_req_valid", {31'b0, req_valid}, 32'd0);
    step(); resp_valid = 1'b0; #1;
    check("rw.dropped_out_valid", {31'b0, out_valid}, 32'd0);
    check("rw.req_valid", {31'b0, req_valid}, 32'd1);
    check("rw.req_addr", req_addr, 32'h8000_0100);

    // Redirect and out_ready together in S_OUT: no transfer, fetch target
    fetch("ro", 32'h8000_0100, 32'h0000_0013);
    step(); out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; #1;
    check("ro.out_valid", {31'b0, out_valid}, 32'd0);
    step(); out_ready = 1'b0; redirect_valid = 1'b0; #1;
    check("ro.out_valid_after", {31'b0, out_valid}, 32'd0);
    check("ro.req_addr", req_addr, 32'h8000_0200);

    // Redirect coinciding with the request handshake: reply is stale
    step(); req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; #1;
    check("rh.req_addr_old", req_addr, 32'h8000_0200);
    step(); req_ready = 1'b0; redirect_valid = 1'b0; resp_valid = 1'b1; resp_data = 32'h1234_5678; #1;
    check("rh.wait_req_valid", {31'b0, req_valid}, 32'd0);
    step(); resp_valid = 1'b0; #1;
    check("rh.out_valid", {31'b0, out_valid}, 32'd0);
    check("rh.req_addr", req_addr, 32'h8000_0300);

    // Redirect in S_REQ without handshake, then PC wrap at top of memory
    step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    check("wrap.redir_req_addr_old", req_addr, 32'h8000_0300);
    step(); redirect_valid = 1'b0; #1;
    check("wrap.req_addr_new", req_addr, 32'hFFFF_FFFC);
    fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0297);
    consume("wrap", 32'h0000_0000);

    // Reset pulse during S_WAIT, stale response after release is ignored
    step(); req_ready = 1'b1; #1;
    check("rp.req_addr", req_addr, 32'h0000_0000);
    step(); req_ready = 1'b0; rst_n = 1'b0; #1;
    check("rp.req_valid", {31'b0, req_valid}, 32'd0);
    check("rp.out_valid", {31'b0, out_valid}, 32'd0);
    check("rp.out_inst", out_inst, 32'h0);
    step(); rst_n = 1'b1; resp_valid = 1'b1; resp_data = 32'hBAD0_BAD0; #1;
    check("rp.rel_req_valid", {31'b0, req_valid}, 32'd1);
    check("rp.rel_req_addr", req_addr, 32'h8000_0000);
    step(); resp_valid = 1'b0; #1;
    check("rp.stale_out_valid", {31'b0, out_valid}, 32'd0);
    check("rp.stale_req_valid", {31'b0, req_valid}, 32'd1);
    check("rp.stale_req_addr", req_addr, 32'h8000_0000);
    fetch("rp", 32'h8000_0000, 32'h0000_0513);
    consume("rp", 32'h8000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
